// File: rtl/cache_axi_pkg.sv
// Shared types and AXI read constants for the cache read arbiter.
// Build option CACHE_ARB_RR_EN selects round-robin grant (see arb2).
package cache_axi_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RET  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [7:0] ARLEN_LINE  = 8'd3;
    localparam logic [7:0] ARLEN_WORD  = 8'd0;
    localparam logic [2:0] ARSIZE_WORD = 3'd2;
    localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/cache_rd_arbiter_arb2.sv
// Two-way grant: fixed dcache priority, or round-robin when
// CACHE_ARB_RR_EN is defined. Bit 0 = icache, bit 1 = dcache.
module arb2 (
    input  logic       clk_g,
    input  logic       resetn,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_gnt
);

`ifdef CACHE_ARB_RR_EN
    // Set when dcache won the last grant; reset favours dcache.
    logic r_last_d;

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            r_last_d <= 1'b0;
        end else if (i_upd) begin
            r_last_d <= o_gnt[1];
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = r_last_d ? 2'b01 : 2'b10;
        end else if (i_req[1]) begin
            o_gnt = 2'b10;
        end else if (i_req[0]) begin
            o_gnt = 2'b01;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{clk_g, resetn, i_upd};
    assign o_gnt = i_req[1] ? 2'b10 : {1'b0, i_req[0]};
`endif

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI read channel between icache and dcache refills.
// Build option CACHE_ARB_RR_EN: round-robin instead of dcache priority.
module cache_rd_arbiter
    import cache_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID_I = 4'd0,
    parameter logic [3:0] AXI_ID_D = 4'd1
) (
    input  logic         clk_g,
    input  logic         resetn,
    input  logic         i_rd_req,
    input  logic         i_rd_uncache,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic [127:0] i_ret_data,
    input  logic         d_rd_req,
    input  logic         d_rd_uncache,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic [127:0] d_ret_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    state_e       r_state;
    owner_e       r_owner;
    logic [31:0]  r_addr;
    logic         r_unc;
    logic [1:0]   r_beat;
    logic         r_done;
    logic [127:0] r_line;
    logic [127:0] r_i_data;
    logic [127:0] r_d_data;

    logic         w_idle;
    logic         w_addr;
    logic         w_data;
    logic         w_ret;
    logic [1:0]   w_req;
    logic [1:0]   w_gnt;
    logic [127:0] w_line_nxt;
    logic [127:0] w_line_fin;
    logic         w_unused;

    assign w_unused = ^{rid, rresp};

    assign w_idle = resetn && (r_state == S_IDLE);
    assign w_addr = resetn && (r_state == S_ADDR);
    assign w_data = resetn && (r_state == S_DATA);
    assign w_ret  = resetn && (r_state == S_RET);

    assign w_req = w_idle ? {d_rd_req, i_rd_req} : 2'b00;

    arb2 u_arb (
        .clk_g  (clk_g),
        .resetn (resetn),
        .i_req  (w_req),
        .i_upd  (|w_gnt),
        .o_gnt  (w_gnt)
    );

    assign i_rd_rdy = w_gnt[0];
    assign d_rd_rdy = w_gnt[1];

    assign arvalid = w_addr;
    assign arid    = !w_addr ? 4'd0
                   : (r_owner == OWN_D) ? AXI_ID_D : AXI_ID_I;
    assign araddr  = !w_addr ? 32'd0
                   : r_unc ? r_addr : {r_addr[31:4], 4'h0};
    assign arlen   = !w_addr ? 8'd0
                   : r_unc ? ARLEN_WORD : ARLEN_LINE;
    assign arsize  = w_addr ? ARSIZE_WORD : 3'd0;
    assign arburst = w_addr ? BURST_INCR : 2'b00;

    assign rready = w_data;

    assign i_ret_valid = w_ret && (r_owner == OWN_I);
    assign d_ret_valid = w_ret && (r_owner == OWN_D);
    assign i_ret_data  = r_i_data;
    assign d_ret_data  = r_d_data;

    // Uncached words land in the top slot; line beats fill upward.
    always_comb begin
        w_line_nxt = r_line;
        if (r_unc) begin
            w_line_nxt[127:96] = rdata;
        end else begin
            w_line_nxt[{r_beat, 5'd0} +: 32] = rdata;
        end
    end

    assign w_line_fin = r_done ? r_line : w_line_nxt;

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_owner  <= OWN_I;
            r_addr   <= 32'd0;
            r_unc    <= 1'b0;
            r_beat   <= 2'd0;
            r_done   <= 1'b0;
            r_line   <= 128'd0;
            r_i_data <= 128'd0;
            r_d_data <= 128'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|w_gnt) begin
                        r_owner <= w_gnt[1] ? OWN_D : OWN_I;
                        r_addr  <= w_gnt[1] ? d_rd_addr : i_rd_addr;
                        r_unc   <= w_gnt[1] ? d_rd_uncache
                                            : i_rd_uncache;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        r_beat  <= 2'd0;
                        r_done  <= 1'b0;
                        r_line  <= 128'd0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rvalid) begin
                        if (!r_done) begin
                            r_line <= w_line_nxt;
                        end
                        r_beat <= r_beat + 2'd1;
                        if (r_unc || (r_beat == 2'd3)) begin
                            r_done <= 1'b1;
                        end
                        if (rlast) begin
                            if (r_owner == OWN_D) begin
                                r_d_data <= w_line_fin;
                            end else begin
                                r_i_data <= w_line_fin;
                            end
                            r_state <= S_RET;
                        end
                    end
                end
                S_RET: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_rd_arbiter.md
CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

Interface
REQ-001 SHALL have parameter AXI_ID_I, default 4'd0, the ARID used for icache transactions.
REQ-002 SHALL have parameter AXI_ID_D, default 4'd1, the ARID used for dcache transactions.
REQ-003 SHALL use clock clk_g and reset resetn (synchronous, active-low).
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk_g  in  1  clock
- resetn  in  1  synchronous active-low reset
- i_rd_req  in  1  icache line/uncached read request
- i_rd_uncache  in  1  icache request is single-word uncached
- i_rd_addr  in  32  icache read address
- i_rd_rdy  out  1  icache request accepted
- i_ret_valid  out  1  icache return data valid
- i_ret_data  out  128  icache return data
- d_rd_req, d_rd_uncache, d_rd_addr, d_rd_rdy, d_ret_valid, d_ret_data: same as the icache ports, dcache side
- arid  out  4  AXI read ID
- araddr  out  32  AXI read address
- arlen  out  8  AXI burst length
- arsize  out  3  AXI beat size
- arburst  out  2  AXI burst type
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- rid  in  4  AXI read ID (ignored)
- rdata  in  32  AXI read data
- rresp  in  2  AXI read response
- rlast  in  1  AXI last beat
- rvalid  in  1  AXI read valid
- rready  out  1  AXI read ready

Function
REQ-005 SHALL implement FSM IDLE -> ADDR -> DATA -> RET -> IDLE, with one outstanding transaction.
REQ-006 In IDLE with any rd_req high, SHALL grant one requester and pulse its rd_rdy for that same cycle.
- SHALL latch owner, address and uncache flag in that cycle.
- SHALL go to ADDR next cycle.
REQ-007 Without the RR option, SHALL grant dcache when both requesters are high in the same cycle.
REQ-008 In ADDR, SHALL drive arvalid=1 and hold all AR fields stable until arready, then go to DATA.
REQ-009 Cached request: arlen=3, arsize=2, arburst=2'b01 (INCR), araddr[3:0] forced to 0.
REQ-010 Uncached request: arlen=0, arsize=2, arburst=2'b01, araddr taken verbatim.
REQ-011 SHALL drive arid from AXI_ID_I or AXI_ID_D according to owner.
REQ-012 In DATA, SHALL drive rready=1 and use a 2-bit beat counter cleared on entry.
- Cached: beat k SHALL be written to line bits [32k+31:32k].
- Uncached: the single beat SHALL be written to bits [127:96]; other bits are 0.
REQ-013 On a DATA beat with rlast=1, SHALL go to RET.
- An early rlast ends the line; unwritten words are left as 0.
- Beats beyond the fourth before rlast SHALL be ignored.
REQ-014 In RET, SHALL pulse the owner's ret_valid for exactly one cycle with the assembled line, then go to IDLE.
- The non-owner's ret_valid SHALL stay 0.
REQ-015 ret_data SHALL hold its last value outside RET.
REQ-016 rresp SHALL be ignored; data is returned regardless of response.
REQ-017 rd_req SHALL be ignored outside IDLE; a requester holds rd_req until it sees its rd_rdy.
REQ-018 Minimum latency from rd_rdy to ret_valid SHALL be 3 cycles for uncached and 6 cycles for a 4-beat line, with arready and rvalid tied high.

Reset
REQ-019 With resetn=0 at a clk_g edge, SHALL enter IDLE and clear the beat counter, the line buffer and the RR pointer.
REQ-020 During reset, arvalid, rready, both rd_rdy and both ret_valid SHALL be 0.
REQ-021 Reset in mid-transaction SHALL abandon the transaction; no ret_valid is issued for it.

Configuration
REQ-022 SHALL implement macro CACHE_ARB_RR_EN.
- Defined: two-way round-robin; on a simultaneous request the requester not granted last SHALL win; the pointer resets to favour dcache.
- Undefined: fixed dcache priority per REQ-007.

Structure
REQ-023 Package cache_axi_pkg SHALL hold the FSM state enum, ARLEN_LINE=3, ARLEN_WORD=0, ARSIZE_WORD=2, BURST_INCR=2'b01 and the owner enum.
REQ-024 Grant logic, including the RR pointer, SHALL be a sub-module arb2 (two requests in, one-hot grant out, plus an update strobe).

Verification
REQ-025 icache cached read 0x1FC0_0014, rdata 0xA,0xB,0xC,0xD -> araddr=0x1FC0_0010, arlen=3, i_ret_data=0x0000000D_0000000C_0000000B_0000000A, one-cycle i_ret_valid, d_ret_valid=0.
REQ-026 dcache uncached read 0xBFAF_8000, rdata 0x1234_5678 -> arlen=0, araddr=0xBFAF_8000, d_ret_data[127:96]=0x1234_5678 and remaining bits 0.
REQ-027 Simultaneous i/d requests twice in a row -> without RR, dcache is granted both times; with CACHE_ARB_RR_EN, the order is dcache then icache.
REQ-028 arready held low 5 cycles -> arvalid stays high and AR fields stay unchanged; exactly one AR handshake occurs.
REQ-029 rvalid gapped (beat, 2 idle, beat, ...) -> line assembled correctly and ret_valid fires one cycle after the rlast beat.
REQ-030 resetn asserted after the second beat -> next cycle is IDLE with all outputs 0; a new request completes normally.
